vx_alu_dot8: RTL and testbench

VX_ALU_DOT8 -- requirements
Module: VX_alu_dot8

---
 rtl/vx_alu_dot8.sv | 133 +++++++++++++
 tb/tb_vx_alu_dot8.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_alu_dot8.sv
// ---------------------------------------------------------------------------
// vx_alu_dot8
//   Per-lane signed int8 4-way dot product with a two-stage pipeline.
//   Each 32-bit lane operand holds four packed int8 values; the lane result is
//   sum(A[k]*B[k]) for k=0..3, sign-extended to 32 bits. Inactive lanes
//   (tmask bit 0) produce zero.
//
//   Stages:
//     S1 : four 16-bit signed products per lane, plus tag/tmask.
//     S2 : 18-bit signed sum, sign-extended, masked. This is the output register.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake
//   in_tmask              : per-lane active mask
//   in_rs1_data           : lane operand A (NUM_LANES x DATAW)
//   in_rs2_data           : lane operand B (NUM_LANES x DATAW)
//   in_tag                : opaque metadata, passed through untouched
//   out_valid / out_ready : result handshake
//   out_tmask, out_data,
//   out_tag               : result of the oldest outstanding request
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid never waits on ready. in_ready is the pipeline enable
// (!out_valid || out_ready) and does not look at in_valid. While out_valid is
// high and out_ready is low, every stage register and output holds.
// ---------------------------------------------------------------------------
module vx_alu_dot8 #(
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 64,
    parameter int DATAW     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES-1:0]       in_tmask,
    input  logic [NUM_LANES*DATAW-1:0] in_rs1_data,
    input  logic [NUM_LANES*DATAW-1:0] in_rs2_data,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_LANES-1:0]       out_tmask,
    output logic [NUM_LANES*DATAW-1:0] out_data,
    output logic [TAG_WIDTH-1:0]       out_tag
);

    // Pipeline enable: both stages advance together.
    logic en;

    // S1 registers
    logic                 s1_valid;
    logic [15:0]          s1_prod [NUM_LANES][4];
    logic [NUM_LANES-1:0] s1_tmask;
    logic [TAG_WIDTH-1:0] s1_tag;

    // S2 registers (output)
    logic                       s2_valid;
    logic [NUM_LANES*DATAW-1:0] s2_data;
    logic [NUM_LANES-1:0]       s2_tmask;
    logic [TAG_WIDTH-1:0]       s2_tag;

    // Combinational stage inputs
    logic [15:0]                prod_d [NUM_LANES][4];
    logic [NUM_LANES*DATAW-1:0] sum_d;

    assign en       = !s2_valid || out_ready;
    assign in_ready = en;

    // Signed 8x8 -> 16 multiply, operands sign-extended explicitly so the
    // product is computed at full 16-bit width.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0]  a8;
                logic [7:0]  b8;
                logic [15:0] a16;
                logic [15:0] b16;
                a8  = in_rs1_data[l*DATAW + 8*k +: 8];
                b8  = in_rs2_data[l*DATAW + 8*k +: 8];
                a16 = {{8{a8[7]}}, a8};
                b16 = {{8{b8[7]}}, b8};
                prod_d[l][k] = 16'($signed(a16) * $signed(b16));
            end
        end
    end

    // Four 16-bit products fit in 18 bits signed; no overflow is possible.
    // Masking is applied here so the output register holds the final value.
    always_comb begin
        sum_d = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            logic [17:0] acc;
            acc = '0;
            for (int k = 0; k < 4; k++) begin
                acc = acc + {{2{s1_prod[l][k][15]}}, s1_prod[l][k]};
            end
            if (s1_tmask[l]) begin
                sum_d[l*DATAW +: DATAW] = {{(DATAW-18){acc[17]}}, acc};
            end
        end
    end

    // Valid bits: the only reset state in the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
        end
    end

    // Datapath/tag registers are not reset; they are don't-care while the
    // matching valid bit is low.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_prod  <= prod_d;
            s1_tmask <= in_tmask;
            s1_tag   <= in_tag;
            s2_data  <= sum_d;
            s2_tmask <= s1_tmask;
            s2_tag   <= s1_tag;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_tmask = s2_tmask;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_vx_alu_dot8.sv
// ---------------------------------------------------------------------------
// tb_vx_alu_dot8
//   Bench for vx_alu_dot8 with NUM_LANES=4, TAG_WIDTH=64.
// ---------------------------------------------------------------------------
module tb_vx_alu_dot8;

    localparam int NL = 4;
    localparam int TW = 64;
    localparam int DW = 32;
    localparam int XW = NL*DW;
    localparam int EW = XW + TW + NL;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [NL-1:0] in_tmask;
    logic [XW-1:0] in_rs1_data;
    logic [XW-1:0] in_rs2_data;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [NL-1:0] out_tmask;
    logic [XW-1:0] out_data;
    logic [TW-1:0] out_tag;

    vx_alu_dot8 #(.NUM_LANES(NL), .TAG_WIDTH(TW), .DATAW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tmask    (in_tmask),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_tmask   (out_tmask),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_delivered = 0;

    // snapshot of the last observed cycle (taken just before the active edge)
    logic          s_valid, s_ready;
    logic [XW-1:0] s_data;
    logic [TW-1:0] s_tag;

    logic          prev_stall = 1'b0;
    logic [XW-1:0] prev_data;
    logic [TW-1:0] prev_tag;
    logic [NL-1:0] prev_tmask;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sbyte(input logic [7:0] x);
        return (int'(x) >= 128) ? int'(x) - 256 : int'(x);
    endfunction

    function automatic logic [XW-1:0] ref_dot(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                             input logic [NL-1:0] m);
        logic [XW-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) begin
            int s;
            s = 0;
            for (int k = 0; k < 4; k++)
                s += sbyte(a[l*DW + 8*k +: 8]) * sbyte(b[l*DW + 8*k +: 8]);
            if (m[l]) r[l*DW +: DW] = s;
        end
        return r;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic v, input logic r, input logic [XW-1:0] a,
                         input logic [XW-1:0] b, input logic [NL-1:0] m,
                         input logic [TW-1:0] t, output logic acc);
        logic [EW-1:0] e;
        @(negedge clk);
        in_valid    = v;
        out_ready   = r;
        in_rs1_data = a;
        in_rs2_data = b;
        in_tmask    = m;
        in_tag      = t;
        #1;
        chk("ready_rule", in_ready, !out_valid || out_ready);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_data);
            chk("stall_tag", out_tag, prev_tag);
            chk("stall_tmask", out_tmask, prev_tmask);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: got data %h tag %h with no request outstanding",
                         out_data, out_tag);
            end else begin
                e = exp_q.pop_front();
                chk("result", {out_data, out_tag, out_tmask}, e);
                n_delivered++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back({ref_dot(a, b, m), t, m});
        if (exp_q.size() > 2) begin
            n_checks++;
            n_errors++;
            $display("FAIL occupancy: got %0d outstanding expected at most 2", exp_q.size());
        end
        s_valid    = out_valid;
        s_ready    = in_ready;
        s_data     = out_data;
        s_tag      = out_tag;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;
        prev_tmask = out_tmask;
        @(posedge clk);
    endtask

    task automatic idle(input logic r);
        logic acc;
        cycle(1'b0, r, '0, '0, '0, '0, acc);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        exp_q.delete();
        prev_stall = 1'b0;
        reset = 1'b0;
    endtask

    function automatic logic [XW-1:0] rep(input logic [31:0] w);
        return {NL{w}};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h80808080;
            1: return 32'h7F7F7F7F;
            2: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        logic [NL-1:0] tmask;
        logic [TW-1:0] tag;
        logic [XW-1:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic acc;
        int   pending;
        int   base;

        vecs[0] = '{32'h01020304, 32'h05060708, 4'b0001, 64'h1111_0000_0000_0001,
                    {32'h0, 32'h0, 32'h0, 32'h00000046}};
        vecs[1] = '{32'h80808080, 32'h80808080, 4'b1111, 64'h2222_0000_0000_0002,
                    {4{32'h00010000}}};
        vecs[2] = '{32'h7F7F7F7F, 32'h80808080, 4'b1111, 64'h3333_0000_0000_0003,
                    {4{32'hFFFF0200}}};
        vecs[3] = '{32'h01020304, 32'h05060708, 4'b0101, 64'hDEAD_BEEF_CAFE_F00D,
                    {32'h0, 32'h00000046, 32'h0, 32'h00000046}};
        vecs[4] = '{32'hFFFFFFFF, 32'h01010101, 4'b1111, 64'h5555_0000_0000_0005,
                    {4{32'hFFFFFFFC}}};
        vecs[5] = '{32'h7F7F7F7F, 32'h7F7F7F7F, 4'b1010, 64'h6666_0000_0000_0006,
                    {32'h0000FC04, 32'h0, 32'h0000FC04, 32'h0}};
        vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 4'b0000, 64'h7777_0000_0000_0007,
                    {4{32'h0}}};

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_tmask    = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        in_tag      = '0;
        do_reset(3);

        // Table vectors: accept, check latency, check value.
        foreach (vecs[i]) begin
            cycle(1'b1, 1'b1, rep(vecs[i].rs1), rep(vecs[i].rs2), vecs[i].tmask, vecs[i].tag, acc);
            chk("vec_accept", acc, 1'b1);
            idle(1'b1);
            chk("vec_latency_n1", s_valid, 1'b0);
            idle(1'b1);
            chk("vec_latency_n2", s_valid, 1'b1);
            chk("vec_data", s_data, vecs[i].exp_data);
            chk("vec_tag", s_tag, vecs[i].tag);
        end

        // Three back-to-back requests with out_ready low on cycles 2..6.
        pending = 0;
        base = n_delivered;
        for (int c = 0; c < 13; c++) begin
            logic r;
            r = !(c >= 2 && c <= 6);
            if (pending < 3) begin
                cycle(1'b1, r, rep($urandom), rep($urandom), 4'b1111,
                      {32'hB0B0_0000, 32'(pending)}, acc);
                if (acc) pending++;
            end else begin
                idle(r);
            end
            if (c >= 2 && c <= 6) chk("stall_in_ready", s_ready, 1'b0);
        end
        chk("stream_delivered", n_delivered - base, 3);
        chk("stream_queue_empty", exp_q.size(), 0);

        // Reset with two requests in flight discards both.
        cycle(1'b1, 1'b1, rep(32'h01020304), rep(32'h05060708), 4'b1111, 64'hAA, acc);
        cycle(1'b1, 1'b1, rep(32'h80808080), rep(32'h80808080), 4'b1111, 64'hBB, acc);
        do_reset(1);
        repeat (6) idle(1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  {rand_word(), rand_word(), rand_word(), rand_word()},
                  {rand_word(), rand_word(), rand_word(), rand_word()},
                  4'($urandom), {$urandom, $urandom}, acc);
        end

        // Drain with a bounded budget.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
